spi_reg_write_arbiter: RTL

Round-robin arbiter and SPI controller that serialises register-write requests from several on-chip requesters into 16-bit SPI write frames for the chip's SPI register peripheral. Frames are R/W=1, 7-bit address, 8-bit data, MSB first, SPI mode 0. The block sits between the requesters (test sequencer, PWM configuration logic, etc.) and the peripheral's copi/sclk/ncs pins. It owns the bus timing, including the slow SCLK the peripheral needs because it samples the SPI pins through 2-FF synchronisers in the same clk domain.

---
 rtl/spi_reg_write_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_write_arbiter.sv
// Arbitrates register-write requests and shifts each one out as a 16-bit mode-0 SPI write frame.
// SPI_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module spi_reg_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic                 sclk,
  output logic                 copi,
  output logic                 ncs,
  output logic                 busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 done
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_RELOAD  = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [HW-1:0]        r_hcnt;
  logic                 r_phase_hi;
  logic [3:0]           r_bcnt;
  logic [GW-1:0]        r_gcnt;
  logic [15:0]          r_frame;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 w_any;
  int                   w_idx;
  logic [NUM_REQ-1:0]   w_onehot;
  logic                 w_half_end;
  logic                 w_last_bit;

`ifndef SPI_ARB_FIXED_PRIO_EN
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0]        r_ptr;
`endif

  // Scan downward so the candidate closest to the priority origin is the one left standing.
  always_comb begin
    w_any = 1'b0;
    w_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      if (req_valid[k]) begin
        w_any = 1'b1;
        w_idx = k;
      end
`else
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_idx = (int'(r_ptr) + k) % NUM_REQ;
      end
`endif
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_onehot[i] = w_any && (w_idx == i);
    end
  end

  assign req_ready  = (r_state == S_IDLE && rst_n) ? w_onehot : '0;
  assign w_half_end = (r_hcnt == '0);
  assign w_last_bit = (r_bcnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_SETUP;
      S_SETUP: if (w_half_end) w_next = S_SHIFT;
      S_SHIFT: if (w_half_end && !r_phase_hi && w_last_bit) w_next = S_GAP;
      S_GAP:   if (r_gcnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt     <= '0;
      r_phase_hi <= 1'b0;
      r_bcnt     <= 4'd0;
      r_gcnt     <= '0;
      r_frame    <= '0;
      r_grant    <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      r_ptr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_hcnt     <= HALF_RELOAD;
            r_phase_hi <= 1'b0;
            r_frame    <= {1'b1, req_addr[7*w_idx +: 7], req_data[8*w_idx +: 8]};
            r_grant    <= w_onehot;
`ifndef SPI_ARB_FIXED_PRIO_EN
            r_ptr      <= PW'((w_idx + 1) % NUM_REQ);
`endif
          end
        end
        S_SETUP: begin
          if (w_half_end) begin
            r_hcnt     <= HALF_RELOAD;
            r_phase_hi <= 1'b1;
            r_bcnt     <= 4'd15;
          end else begin
            r_hcnt <= r_hcnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (!w_half_end) begin
            r_hcnt <= r_hcnt - 1'b1;
          end else begin
            r_hcnt <= HALF_RELOAD;
            if (r_phase_hi) begin
              // Falling sclk: present the next bit, but hold the final bit through ncs hold time.
              r_phase_hi <= 1'b0;
              if (!w_last_bit) r_frame <= r_frame << 1;
            end else if (!w_last_bit) begin
              r_bcnt     <= r_bcnt - 4'd1;
              r_phase_hi <= 1'b1;
            end else begin
              r_gcnt <= GAP_RELOAD;
            end
          end
        end
        S_GAP: begin
          if (r_gcnt != '0) r_gcnt <= r_gcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ncs   = 1'b1;
    sclk  = 1'b0;
    copi  = 1'b0;
    busy  = (r_state != S_IDLE);
    grant = '0;
    done  = 1'b0;
    case (r_state)
      S_SETUP: begin
        ncs   = 1'b0;
        copi  = r_frame[15];
        grant = r_grant;
      end
      S_SHIFT: begin
        ncs   = 1'b0;
        sclk  = r_phase_hi;
        copi  = r_frame[15];
        grant = r_grant;
      end
      S_GAP:   done = (r_gcnt == GAP_RELOAD);
      default: ;
    endcase
  end

endmodule
